// File: rtl/pc_unit_24bit.sv
// Program-counter stage: holds PC, issues fetch requests with valid/ready, handles stall/redirect/halt.
// Optional accepted-fetch counter built only when PC_FETCH_COUNT_EN is defined.
module pc_unit_24bit #(
  parameter logic [23:0] RESET_VECTOR = 24'h000000,
  parameter logic [23:0] INC          = 24'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] pc_next_in,
  input  logic        pc_sel,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        fetch_ready,
  output logic [23:0] pc_out,
  output logic [23:0] pc_plus_inc,
  output logic        fetch_valid,
  output logic        halted,
  output logic [23:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        halted_q, halted_d;
  logic        accept;

  assign pc_plus_inc = pc_q + INC;
  assign accept      = (state_q == RUN) & fetch_valid_q & fetch_ready & ~stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Redirect outranks the sequential step and flushes any unaccepted fetch.
        if (!stall) begin
          if (pc_sel) begin
            pc_d = pc_next_in;
          end else if (accept) begin
            pc_d = pc_plus_inc;
          end
          if (halt_req) begin
            state_d = HALT;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
    fetch_valid_d = (state_d == RUN);
    halted_d      = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

`ifdef PC_FETCH_COUNT_EN
  logic [23:0] count_q, count_d;

  // Saturating so a long-running core never reports a wrapped small count.
  always_comb begin
    count_d = count_q;
    if (accept && (count_q != 24'hFFFFFF)) begin
      count_d = count_q + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 24'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 24'h000000;
`endif

  assign pc_out      = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_unit_24bit.sv
// Scoreboard bench for pc_unit_24bit: a reference model pushes expected outputs per cycle,
// each scenario task pops and compares after the clock edge.
module tb_pc_unit_24bit;

  localparam logic [23:0] RV = 24'h000100;

  logic        clk;
  logic        reset;
  logic [23:0] pc_next_in;
  logic        pc_sel;
  logic        stall;
  logic        halt_req;
  logic        fetch_ready;
  logic [23:0] pc_out;
  logic [23:0] pc_plus_inc;
  logic        fetch_valid;
  logic        halted;
  logic [23:0] fetch_count;

  pc_unit_24bit #(.RESET_VECTOR(RV), .INC(24'd1)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_next_in (pc_next_in),
    .pc_sel     (pc_sel),
    .stall      (stall),
    .halt_req   (halt_req),
    .fetch_ready(fetch_ready),
    .pc_out     (pc_out),
    .pc_plus_inc(pc_plus_inc),
    .fetch_valid(fetch_valid),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] pc;
    logic        fv;
    logic        h;
    logic [23:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: 0=BOOT 1=RUN 2=HALT
  int          m_st;
  logic [23:0] m_pc;
  logic [23:0] m_cnt;

  function automatic obs_t sample();
    obs_t o;
    o.pc  = pc_out;
    o.fv  = fetch_valid;
    o.h   = halted;
    o.cnt = fetch_count;
    return o;
  endfunction

  task automatic drive(input logic rst, input logic sel, input logic stl,
                       input logic hlt, input logic rdy, input logic [23:0] nxt);
    obs_t e;
    reset = rst; pc_sel = sel; stall = stl; halt_req = hlt; fetch_ready = rdy; pc_next_in = nxt;
    if (rst) begin
      m_st = 0; m_pc = RV; m_cnt = 24'd0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1 && !stl) begin
      if (rdy) begin
`ifdef PC_FETCH_COUNT_EN
        if (m_cnt != 24'hFFFFFF) m_cnt = m_cnt + 24'd1;
`endif
      end
      if (sel) m_pc = nxt;
      else if (rdy) m_pc = m_pc + 24'd1;
      if (hlt) m_st = 2;
    end
    e.pc = m_pc; e.fv = (m_st == 1); e.h = (m_st == 2); e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 0, 0, 0, 1, 24'h0);
      else        drive(0, 0, 0, 0, 1, 24'h0);
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_seq[%0d]: got pc=%h fv=%b h=%b cnt=%h, expected pc=%h fv=%b h=%b cnt=%h",
                 i, o.pc, o.fv, o.h, o.cnt, e.pc, e.fv, e.h, e.cnt);
      end
    end
    // Independent of the model: after reset, BOOT, then 100,101,102 pattern.
    checks++;
    if (pc_out !== 24'h000102) begin
      errors++; $display("FAIL reset_step_pc: got %h, expected 000102", pc_out);
    end
  endtask

  task automatic test_ready_hold();
    obs_t e, o;
    logic [23:0] c0;
    drive(0, 1, 0, 0, 0, 24'h000010);
    void'(exp_q.pop_front());
    c0 = fetch_count;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, (i == 3), 24'h0);
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ready_hold[%0d]: got pc=%h fv=%b h=%b cnt=%h, expected pc=%h fv=%b h=%b cnt=%h",
                 i, o.pc, o.fv, o.h, o.cnt, e.pc, e.fv, e.h, e.cnt);
      end
    end
    checks++;
`ifdef PC_FETCH_COUNT_EN
    if (fetch_count !== c0 + 24'd1) begin
      errors++; $display("FAIL ready_hold_count: got %h, expected %h", fetch_count, c0 + 24'd1);
    end
`else
    if (fetch_count !== 24'h0 || c0 !== 24'h0) begin
      errors++; $display("FAIL ready_hold_count: got %h, expected 000000", fetch_count);
    end
`endif
  endtask

  task automatic test_redirect();
    obs_t e, o;
    logic sel_t[4] = '{1, 1, 1, 1};
    logic stl_t[4] = '{0, 0, 0, 1};
    logic [23:0] nxt_t[4] = '{24'h000020, 24'h0ABCDE, 24'h000020, 24'h0ABCDE};
    for (int i = 0; i < 4; i++) begin
      drive(0, sel_t[i], stl_t[i], 0, 0, nxt_t[i]);
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL redirect[%0d]: got pc=%h fv=%b h=%b cnt=%h, expected pc=%h fv=%b h=%b cnt=%h",
                 i, o.pc, o.fv, o.h, o.cnt, e.pc, e.fv, e.h, e.cnt);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    drive(0, 1, 0, 0, 0, 24'hFFFFFF);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL wrap_load: got pc=%h fv=%b, expected pc=%h fv=%b", o.pc, o.fv, e.pc, e.fv);
    end
    checks++;
    if (pc_plus_inc !== 24'h000000) begin
      errors++; $display("FAIL wrap_plus_inc: got %h, expected 000000", pc_plus_inc);
    end
    drive(0, 0, 0, 0, 1, 24'h0);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL wrap_step: got pc=%h cnt=%h, expected pc=%h cnt=%h", o.pc, o.cnt, e.pc, e.cnt);
    end
  endtask

  task automatic test_halt();
    obs_t e, o;
    logic rst_t[7] = '{0, 0, 0, 0, 0, 0, 1};
    logic sel_t[7] = '{1, 0, 1, 0, 0, 1, 1};
    logic stl_t[7] = '{0, 0, 0, 1, 0, 0, 0};
    logic hlt_t[7] = '{0, 1, 0, 0, 1, 1, 0};
    logic rdy_t[7] = '{0, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      drive(rst_t[i], sel_t[i], stl_t[i], hlt_t[i], rdy_t[i], (i == 0) ? 24'h000030 : 24'h0BEEF0);
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL halt[%0d]: got pc=%h fv=%b h=%b cnt=%h, expected pc=%h fv=%b h=%b cnt=%h",
                 i, o.pc, o.fv, o.h, o.cnt, e.pc, e.fv, e.h, e.cnt);
      end
      if (i == 1) begin
        checks++;
        if (pc_out !== 24'h000031 || halted !== 1'b1 || fetch_valid !== 1'b0) begin
          errors++;
          $display("FAIL halt_entry: got pc=%h h=%b fv=%b, expected pc=000031 h=1 fv=0",
                   pc_out, halted, fetch_valid);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    obs_t e, o;
    drive(0, 0, 0, 0, 1, 24'h0);
    void'(exp_q.pop_front());
    drive(0, 0, 0, 0, 1, 24'h0);
    void'(exp_q.pop_front());
    drive(1, 1, 0, 0, 0, 24'h055555);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e || pc_out !== RV) begin
      errors++;
      $display("FAIL reset_mid: got pc=%h fv=%b h=%b cnt=%h, expected pc=%h fv=%b h=%b cnt=%h",
               o.pc, o.fv, o.h, o.cnt, e.pc, e.fv, e.h, e.cnt);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    int bad = 0;
    drive(0, 0, 0, 0, 1, 24'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), 24'($urandom));
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        if (bad < 5)
          $display("FAIL b2b[%0d]: got pc=%h fv=%b h=%b cnt=%h, expected pc=%h fv=%b h=%b cnt=%h",
                   i, o.pc, o.fv, o.h, o.cnt, e.pc, e.fv, e.h, e.cnt);
        bad++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; pc_sel = 1'b0; stall = 1'b0; halt_req = 1'b0; fetch_ready = 1'b0;
    pc_next_in = 24'h0;
    m_st = 0; m_pc = RV; m_cnt = 24'd0;
    #2;
    test_reset();
    test_ready_hold();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
